// File: rtl/counter_mod.sv
// counter_mod: modulo up/down counter with enable, clear, load,
// terminal-count pulse and optional prescaler (COUNTER_MOD_PRESCALER_EN).
// Ports: clk_i, nrst_i, clr_i, load_i, load_val_i, en_i, up_i, presc_i
//        -> counter_val_o (registered count), tc_o (registered wrap pulse)
module counter_mod #(
  parameter int              BW       = 8,
  parameter longint unsigned MODULO   = 64'd1 << BW,
  parameter int              PRESC_BW = 4
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  input  logic                clr_i,
  input  logic                load_i,
  input  logic [BW-1:0]       load_val_i,
  input  logic                en_i,
  input  logic                up_i,
  input  logic [PRESC_BW-1:0] presc_i,
  output logic [BW-1:0]       counter_val_o,
  output logic                tc_o
);

  localparam logic [BW:0] TOP = (BW+1)'(MODULO - 64'd1);

  logic [BW-1:0] count_q;
  logic          tc_q;
  logic          tick;

  logic [BW:0] cur_ext;
  logic [BW:0] ld_ext;
  logic [BW:0] ld_clamp;
  logic [BW:0] step_nxt;
  logic        step_wrap;

  assign cur_ext  = {1'b0, count_q};
  assign ld_ext   = {1'b0, load_val_i};
  assign ld_clamp = (ld_ext > TOP) ? TOP : ld_ext;

  // Compare-based wrap; BW+1 bit math keeps MODULO = 2**BW exact.
  always_comb begin
    step_nxt  = cur_ext;
    step_wrap = 1'b0;
    if (up_i) begin
      if (cur_ext == TOP) begin
        step_nxt  = '0;
        step_wrap = 1'b1;
      end else begin
        step_nxt = cur_ext + 1'b1;
      end
    end else begin
      if (cur_ext == '0) begin
        step_nxt  = TOP;
        step_wrap = 1'b1;
      end else begin
        step_nxt = cur_ext - 1'b1;
      end
    end
  end

`ifdef COUNTER_MOD_PRESCALER_EN
  logic [PRESC_BW-1:0] presc_q;

  assign tick = (presc_q == presc_i);

  // Lowering presc_i below presc_q lets it wrap naturally.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      presc_q <= '0;
    end else if (clr_i || load_i) begin
      presc_q <= '0;
    end else if (en_i) begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
    end
  end
`else
  logic unused_presc;

  assign unused_presc = ^presc_i;
  assign tick         = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else if (clr_i) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else if (load_i) begin
      count_q <= ld_clamp[BW-1:0];
      tc_q    <= 1'b0;
    end else if (en_i && tick) begin
      count_q <= step_nxt[BW-1:0];
      tc_q    <= step_wrap;
    end else begin
      tc_q    <= 1'b0;
    end
  end

  assign counter_val_o = count_q;
  assign tc_o          = tc_q;

endmodule

// File: tb/tb_counter_mod.sv
// tb_counter_mod: directed self-checking bench for counter_mod.
// Instances: BW=4/MODULO=10 and BW=8/MODULO=256.
module tb_counter_mod;

  logic       clk;
  logic       nrst;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic       en;
  logic       up;
  logic [3:0] presc;
  logic [3:0] val4;
  logic       tc4;
  logic [7:0] val8;
  logic       tc8;

  int checks   = 0;
  int failures = 0;

  counter_mod #(.BW(4), .MODULO(10), .PRESC_BW(4)) u4 (
    .clk_i        (clk),
    .nrst_i       (nrst),
    .clr_i        (clr),
    .load_i       (load),
    .load_val_i   (load_val[3:0]),
    .en_i         (en),
    .up_i         (up),
    .presc_i      (presc),
    .counter_val_o(val4),
    .tc_o         (tc4)
  );

  counter_mod #(.BW(8), .MODULO(256), .PRESC_BW(4)) u8 (
    .clk_i        (clk),
    .nrst_i       (nrst),
    .clr_i        (clr),
    .load_i       (load),
    .load_val_i   (load_val),
    .en_i         (en),
    .up_i         (up),
    .presc_i      (presc),
    .counter_val_o(val8),
    .tc_o         (tc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst     = 1'b0;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = '0;
    en       = 1'b1;
    up       = 1'b1;
    presc    = '0;
    #3;
    chk("rst_val4", int'(val4), 0);
    chk("rst_tc4", int'(tc4), 0);
    chk("rst_val8", int'(val8), 0);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 1; i <= 12; i++) begin
      step();
      chk("up_val", int'(val4), i % 10);
      chk("up_tc", int'(tc4), (i == 10) ? 1 : 0);
    end

    up = 1'b0;
    step(); chk("dn_val0", int'(val4), 1); chk("dn_tc0", int'(tc4), 0);
    step(); chk("dn_val1", int'(val4), 0); chk("dn_tc1", int'(tc4), 0);
    step(); chk("dn_val2", int'(val4), 9); chk("dn_tc2", int'(tc4), 1);
    step(); chk("dn_val3", int'(val4), 8); chk("dn_tc3", int'(tc4), 0);

    load     = 1'b1;
    load_val = 8'd15;
    step(); chk("ld_clamp", int'(val4), 9); chk("ld_tc", int'(tc4), 0);
    load = 1'b0;
    up   = 1'b1;
    step(); chk("ld_wrap", int'(val4), 0); chk("ld_wrap_tc", int'(tc4), 1);
    step(); chk("pre_clr", int'(val4), 1);
    clr      = 1'b1;
    load     = 1'b1;
    load_val = 8'd5;
    step(); chk("clr_prio", int'(val4), 0); chk("clr_tc", int'(tc4), 0);
    clr = 1'b0;

    load_val = 8'd3;
    step(); chk("ld3", int'(val4), 3);
    load = 1'b0;
    en   = 1'b1;
    step(); chk("en1", int'(val4), 4);
    en = 1'b0;
    step(); chk("en0a", int'(val4), 4);
    step(); chk("en0b", int'(val4), 4);
    en = 1'b1;
    step(); chk("en1b", int'(val4), 5);

    load     = 1'b1;
    load_val = 8'd7;
    step(); chk("ld7", int'(val4), 7);
    load = 1'b0;
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_val", int'(val4), 0);
    chk("arst_tc", int'(tc4), 0);
    @(negedge clk);
    nrst = 1'b1;
    step(); chk("post_rst", int'(val4), 1);

    load     = 1'b1;
    load_val = 8'd255;
    step(); chk("ld255", int'(val8), 255);
    load = 1'b0;
    up   = 1'b1;
    step(); chk("w8_up", int'(val8), 0); chk("w8_up_tc", int'(tc8), 1);
    up = 1'b0;
    step(); chk("w8_dn", int'(val8), 255); chk("w8_dn_tc", int'(tc8), 1);
    step(); chk("w8_dn2", int'(val8), 254); chk("w8_dn2_tc", int'(tc8), 0);

`ifdef COUNTER_MOD_PRESCALER_EN
    up       = 1'b1;
    en       = 1'b1;
    presc    = 4'd3;
    load     = 1'b1;
    load_val = 8'd0;
    step(); chk("ps_ld0", int'(val4), 0);
    load = 1'b0;
    step(); chk("ps_a1", int'(val4), 0);
    step(); chk("ps_a2", int'(val4), 0);
    step(); chk("ps_a3", int'(val4), 0);
    step(); chk("ps_a4", int'(val4), 1);
    step(); chk("ps_b1", int'(val4), 1);
    step(); chk("ps_b2", int'(val4), 1);
    load     = 1'b1;
    load_val = 8'd5;
    step(); chk("ps_ld5", int'(val4), 5);
    load = 1'b0;
    step(); chk("ps_c1", int'(val4), 5);
    step(); chk("ps_c2", int'(val4), 5);
    step(); chk("ps_c3", int'(val4), 5);
    step(); chk("ps_c4", int'(val4), 6);
    presc = 4'd0;
    step(); chk("ps_d1", int'(val4), 7);
    step(); chk("ps_d2", int'(val4), 8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
